regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the pipelined CPU, replacing the fixed 32×32, two-read-port register file. It provides NREAD registered read ports with same-cycle write bypass, one write port, a combinational debug read port, and an integrated busy-bit scoreboard that the decode stage uses to detect pending writes. It sits between decode (reads, scoreboard set) and write-back (writes, scoreboard clear).

## Interface
Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width. Depth is 2**ADDR_W.
- NREAD, 2: number of read ports, minimum 1.
- ZERO_REG, 1: when 1, register 0 reads as 0 and ignores writes and scoreboard sets.

Ports:
- PCclk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_en  in  NREAD  per-port read enable.
- rd_addr  in  NREAD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NREAD*DATA_W  registered read data, packed the same way.
- rd_busy  out  NREAD  registered scoreboard status of the address read.
- wr_en  in  1  write enable; also clears the scoreboard bit.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- sb_set  in  1  marks sb_addr as having a pending write.
- sb_addr  in  ADDR_W  scoreboard set address.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  combinational contents of register dbg_addr (no bypass).
- busy_vec  out  2**ADDR_W  current scoreboard bits, direct register output.

## Operation
- Storage: 2**ADDR_W × DATA_W array. Writes happen at the edge when wr_en=1, except writes to address 0 when ZERO_REG=1.
- Read port k: at the edge with rd_en[k]=1, rd_data[k] captures the value.
  - If wr_en=1 and wr_addr=rd_addr[k] in the same cycle, and the write is not a suppressed write to r0, it captures wr_data (bypass).
  - Otherwise it captures array[rd_addr[k]].
  - When rd_en[k]=0, rd_data[k] and rd_busy[k] hold their values.
- Port reads are independent. Any number of ports may read the same address.
- Scoreboard:
  - sb_set sets busy[sb_addr].
  - wr_en clears busy[wr_addr].
  - Set and clear to the same address in the same cycle: set wins, because a new producer has issued.
  - Address 0 is never busy when ZERO_REG=1.
- rd_busy[k] captures busy[rd_addr[k]] & ~(wr_en & wr_addr==rd_addr[k]). This is the pre-set state with the same-cycle clear applied; a same-cycle sb_set to that address is not visible.
- dbg_data = array[dbg_addr] combinationally. It is 0 for address 0 when ZERO_REG=1.

## Timing
- Read latency is 1 cycle: the address is sampled at edge n, and rd_data/rd_busy are valid after edge n until the next enabled read.
- Write latency: visible in the array and on dbg_data after the edge. A same-cycle read sees it through the bypass.
- Scoreboard update takes effect after the edge. A read at the same edge sees the old set state.
- Reset, asynchronous on the falling edge of rst_n, held while rst_n=0:
  - every array entry = 0
  - busy_vec = 0
  - rd_data = 0
  - rd_busy = 0
  - dbg_data reflects the zeroed array.
- Reset release mid-operation: the first edge with rst_n=1 behaves normally. Inputs sampled during reset are discarded.
- No X propagation: all outputs are defined from reset onward.

## Structure
- Package regfile_pkg holds:
  - defaults DATA_W_DEF=32, ADDR_W_DEF=5, NREAD_DEF=2
  - the function for the packed-port slice offset.
- One sub-module, regfile_scoreboard: the busy-bit vector with set/clear priority and the ZERO_REG mask. Its ports are clk, rst_n, set, set_addr, clr, clr_addr, and busy_vec.
- Read ports are generated with a for-generate over NREAD.

## Test plan
- Reset, then read r0–r31 on both ports -> all rd_data=0, busy_vec=0. Assert rst_n=0 mid-run after writing r5=0xDEADBEEF -> r5 immediately reads 0 on dbg_data.
- Write r3=0x12345678 and read r3 on port 0 in the same cycle -> rd_data[0]=0x12345678 one cycle later (bypass). Next cycle, with rd_en[0]=0 -> value held.
- Write r0=0xFFFFFFFF and set sb r0, with ZERO_REG=1 -> read r0=0, busy_vec[0]=0, dbg_data=0. With ZERO_REG=0 -> reads 0xFFFFFFFF.
- sb_set r7, next cycle read r7 -> rd_busy=1. Then wr_en r7 + sb_set r7 in the same cycle -> busy_vec[7] remains 1. Then wr_en r7 alone -> busy_vec[7]=0.
- Read r9 while a same-cycle write to r9 clears busy -> rd_busy=0 and data=new value.
- NREAD=4, DATA_W=64, ADDR_W=4: four ports read r1,r2,r1,r15 after writes of 0x1,0x2,0xF -> outputs 0x1,0x2,0x1,0xF.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREAD_DEF  = 2;

  // Low bit of port k inside a packed multi-port bus of w-bit fields.
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit vector tracking registers with a pending write; set beats clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   set,
  input  logic [ADDR_W-1:0]      set_addr,
  input  logic                   clr,
  input  logic [ADDR_W-1:0]      clr_addr,
  output logic [2**ADDR_W-1:0]   busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  // Clear first, then set: a new producer issuing in the same cycle as the
  // old one retires must leave the register marked busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (clr) w_busy_nxt[clr_addr] = 1'b0;
    if (set) w_busy_nxt[set_addr] = 1'b1;
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NREAD registered read ports with write bypass,
// one write port, combinational debug read and an integrated busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NREAD    = NREAD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                      PCclk,
  input  logic                      rst_n,
  input  logic [NREAD-1:0]          rd_en,
  input  logic [NREAD*ADDR_W-1:0]   rd_addr,
  output logic [NREAD*DATA_W-1:0]   rd_data,
  output logic [NREAD-1:0]          rd_busy,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      sb_set,
  input  logic [ADDR_W-1:0]         sb_addr,
  input  logic [ADDR_W-1:0]         dbg_addr,
  output logic [DATA_W-1:0]         dbg_data,
  output logic [2**ADDR_W-1:0]      busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_busy;
  logic              w_wr_ok;

  // A write to r0 is dropped entirely when r0 is hard-wired to zero.
  assign w_wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge PCclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (PCclk),
    .rst_n    (rst_n),
    .set      (sb_set),
    .set_addr (sb_addr),
    .clr      (wr_en),
    .clr_addr (wr_addr),
    .busy_vec (w_busy)
  );

  assign busy_vec = w_busy;
  assign dbg_data = ((ZERO_REG != 0) && (dbg_addr == '0)) ? '0 : r_mem[dbg_addr];

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_hit;
    logic              w_byp;
    logic [DATA_W-1:0] r_data;
    logic              r_busy;

    assign w_addr = rd_addr[slice_lo(k, ADDR_W) +: ADDR_W];
    assign w_hit  = wr_en && (wr_addr == w_addr);
    assign w_byp  = w_hit && w_wr_ok;

    // Busy is the pre-set view with this cycle's write-back clear applied.
    always_ff @(posedge PCclk or negedge rst_n) begin
      if (!rst_n) begin
        r_data <= '0;
        r_busy <= 1'b0;
      end else if (rd_en[k]) begin
        r_data <= w_byp ? wr_data : r_mem[w_addr];
        r_busy <= w_busy[w_addr] & ~w_hit;
      end
    end

    assign rd_data[slice_lo(k, DATA_W) +: DATA_W] = r_data;
    assign rd_busy[k] = r_busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default, ZERO_REG=0 and 4-port/64-bit instances.
module tb_regfile_mp;

  logic PCclk = 1'b0;
  logic rst_n;
  always #5 PCclk = ~PCclk;

  // Default instance
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] busy_vec;

  // ZERO_REG=0 instance
  logic [1:0]  nz_rd_en;
  logic [9:0]  nz_rd_addr;
  logic [63:0] nz_rd_data;
  logic [1:0]  nz_rd_busy;
  logic        nz_wr_en;
  logic [4:0]  nz_wr_addr;
  logic [31:0] nz_wr_data;
  logic        nz_sb_set;
  logic [4:0]  nz_sb_addr;
  logic [4:0]  nz_dbg_addr;
  logic [31:0] nz_dbg_data;
  logic [31:0] nz_busy_vec;

  // NREAD=4, DATA_W=64, ADDR_W=4 instance
  logic [3:0]   w4_rd_en;
  logic [15:0]  w4_rd_addr;
  logic [255:0] w4_rd_data;
  logic [3:0]   w4_rd_busy;
  logic         w4_wr_en;
  logic [3:0]   w4_wr_addr;
  logic [63:0]  w4_wr_data;
  logic         w4_sb_set;
  logic [3:0]   w4_sb_addr;
  logic [3:0]   w4_dbg_addr;
  logic [63:0]  w4_dbg_data;
  logic [15:0]  w4_busy_vec;

  regfile_mp dut (
    .PCclk(PCclk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy_vec(busy_vec)
  );

  regfile_mp #(.ZERO_REG(0)) dut_nz (
    .PCclk(PCclk), .rst_n(rst_n), .rd_en(nz_rd_en), .rd_addr(nz_rd_addr),
    .rd_data(nz_rd_data), .rd_busy(nz_rd_busy), .wr_en(nz_wr_en),
    .wr_addr(nz_wr_addr), .wr_data(nz_wr_data), .sb_set(nz_sb_set),
    .sb_addr(nz_sb_addr), .dbg_addr(nz_dbg_addr), .dbg_data(nz_dbg_data),
    .busy_vec(nz_busy_vec)
  );

  regfile_mp #(.DATA_W(64), .ADDR_W(4), .NREAD(4)) dut_w4 (
    .PCclk(PCclk), .rst_n(rst_n), .rd_en(w4_rd_en), .rd_addr(w4_rd_addr),
    .rd_data(w4_rd_data), .rd_busy(w4_rd_busy), .wr_en(w4_wr_en),
    .wr_addr(w4_wr_addr), .wr_data(w4_wr_data), .sb_set(w4_sb_set),
    .sb_addr(w4_sb_addr), .dbg_addr(w4_dbg_addr), .dbg_data(w4_dbg_data),
    .busy_vec(w4_busy_vec)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic        expb_q[$];

  logic [31:0] mdl_mem [32];
  logic [31:0] mdl_busy;

  task automatic tick();
    @(posedge PCclk);
    #1;
  endtask

  task automatic idle_all();
    rd_en = '0; wr_en = 1'b0; sb_set = 1'b0;
    nz_rd_en = '0; nz_wr_en = 1'b0; nz_sb_set = 1'b0;
    w4_rd_en = '0; w4_wr_en = 1'b0; w4_sb_set = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] e;
    rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy_vec); end
    n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL reset_rd_busy: got %b want 00", rd_busy); end
    dbg_addr = 5'd17; #1;
    n_checks++; if (dbg_data !== 32'h0) begin n_fail++; $display("FAIL reset_dbg: got %h want 0", dbg_data); end
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_en = 2'b11;
      rd_addr = {i[4:0], i[4:0]};
      exp_q.push_back(64'h0);
      exp_q.push_back(64'h0);
      tick();
      e = exp_q.pop_front();
      n_checks++; if (rd_data[31:0] !== e[31:0]) begin n_fail++; $display("FAIL reset_read_p0 r%0d: got %h want %h", i, rd_data[31:0], e[31:0]); end
      e = exp_q.pop_front();
      n_checks++; if (rd_data[63:32] !== e[31:0]) begin n_fail++; $display("FAIL reset_read_p1 r%0d: got %h want %h", i, rd_data[63:32], e[31:0]); end
    end
    rd_en = 2'b00;
    n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL reset_busy_after_reads: got %h want 0", busy_vec); end

    // Mid-run reset wipes the array asynchronously.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; dbg_addr = 5'd5;
    tick();
    wr_en = 1'b0;
    n_checks++; if (dbg_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mid_reset_pre: got %h want deadbeef", dbg_data); end
    rst_n = 1'b0;
    #2;
    n_checks++; if (dbg_data !== 32'h0) begin n_fail++; $display("FAIL mid_reset_async: got %h want 0", dbg_data); end
    // A write presented during reset must be discarded.
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66666666;
    tick();
    wr_en = 1'b0;
    rst_n = 1'b1;
    dbg_addr = 5'd6; #1;
    n_checks++; if (dbg_data !== 32'h0) begin n_fail++; $display("FAIL reset_discard_write: got %h want 0", dbg_data); end
  endtask

  task automatic test_bypass();
    logic [63:0] e;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
    exp_q.push_back(64'h12345678);
    tick();
    e = exp_q.pop_front();
    n_checks++; if (rd_data[31:0] !== e[31:0]) begin n_fail++; $display("FAIL bypass_p0: got %h want %h", rd_data[31:0], e[31:0]); end
    wr_data = 32'hAAAA5555; rd_en = 2'b00; rd_addr = {5'd0, 5'd4};
    exp_q.push_back(64'h12345678);
    tick();
    wr_en = 1'b0;
    e = exp_q.pop_front();
    n_checks++; if (rd_data[31:0] !== e[31:0]) begin n_fail++; $display("FAIL hold_p0: got %h want %h", rd_data[31:0], e[31:0]); end
    dbg_addr = 5'd3; #1;
    n_checks++; if (dbg_data !== 32'hAAAA5555) begin n_fail++; $display("FAIL dbg_after_write: got %h want aaaa5555", dbg_data); end
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    sb_set = 1'b1; sb_addr = 5'd0;
    rd_en = 2'b10; rd_addr = {5'd0, 5'd0};
    nz_wr_en = 1'b1; nz_wr_addr = 5'd0; nz_wr_data = 32'hFFFFFFFF;
    nz_sb_set = 1'b1; nz_sb_addr = 5'd0;
    tick();
    n_checks++; if (rd_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL zero_bypass: got %h want 0", rd_data[63:32]); end
    idle_all();
    rd_en = 2'b10; nz_rd_en = 2'b01; nz_rd_addr = 10'd0; dbg_addr = 5'd0; nz_dbg_addr = 5'd0;
    tick();
    rd_en = 2'b00; nz_rd_en = 2'b00;
    n_checks++; if (rd_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL zero_read: got %h want 0", rd_data[63:32]); end
    n_checks++; if (busy_vec[0] !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b want 0", busy_vec[0]); end
    n_checks++; if (dbg_data !== 32'h0) begin n_fail++; $display("FAIL zero_dbg: got %h want 0", dbg_data); end
    n_checks++; if (nz_rd_data[31:0] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL nz_read: got %h want ffffffff", nz_rd_data[31:0]); end
    n_checks++; if (nz_busy_vec[0] !== 1'b1) begin n_fail++; $display("FAIL nz_busy: got %b want 1", nz_busy_vec[0]); end
    n_checks++; if (nz_dbg_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL nz_dbg: got %h want ffffffff", nz_dbg_data); end
  endtask

  task automatic test_scoreboard();
    sb_set = 1'b1; sb_addr = 5'd7;
    tick();
    sb_set = 1'b0;
    n_checks++; if (busy_vec[7] !== 1'b1) begin n_fail++; $display("FAIL sb_set7: got %b want 1", busy_vec[7]); end
    rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    tick();
    rd_en = 2'b00;
    n_checks++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL rd_busy7: got %b want 1", rd_busy[0]); end
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h7; sb_set = 1'b1; sb_addr = 5'd7;
    tick();
    sb_set = 1'b0;
    n_checks++; if (busy_vec[7] !== 1'b1) begin n_fail++; $display("FAIL set_wins: got %b want 1", busy_vec[7]); end
    tick();
    wr_en = 1'b0;
    n_checks++; if (busy_vec[7] !== 1'b0) begin n_fail++; $display("FAIL clear7: got %b want 0", busy_vec[7]); end
    // A read at the same edge as the set sees the old state.
    sb_set = 1'b1; sb_addr = 5'd8; rd_en = 2'b10; rd_addr = {5'd8, 5'd0};
    tick();
    sb_set = 1'b0; rd_en = 2'b00;
    n_checks++; if (rd_busy[1] !== 1'b0) begin n_fail++; $display("FAIL set_invisible: got %b want 0", rd_busy[1]); end
    n_checks++; if (busy_vec[8] !== 1'b1) begin n_fail++; $display("FAIL sb_set8: got %b want 1", busy_vec[8]); end
  endtask

  task automatic test_clear_bypass();
    sb_set = 1'b1; sb_addr = 5'd9;
    tick();
    sb_set = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9999CAFE;
    rd_en = 2'b10; rd_addr = {5'd9, 5'd0};
    tick();
    wr_en = 1'b0; rd_en = 2'b00;
    n_checks++; if (rd_busy[1] !== 1'b0) begin n_fail++; $display("FAIL clr_byp_busy: got %b want 0", rd_busy[1]); end
    n_checks++; if (rd_data[63:32] !== 32'h9999CAFE) begin n_fail++; $display("FAIL clr_byp_data: got %h want 9999cafe", rd_data[63:32]); end
    n_checks++; if (busy_vec[9] !== 1'b0) begin n_fail++; $display("FAIL clr_byp_vec: got %b want 0", busy_vec[9]); end
  endtask

  task automatic test_wide();
    logic [63:0] e;
    logic [3:0] addrs [4];
    addrs[0] = 4'd1; addrs[1] = 4'd2; addrs[2] = 4'd1; addrs[3] = 4'd15;
    w4_wr_en = 1'b1;
    w4_wr_addr = 4'd1;  w4_wr_data = 64'h1; tick();
    w4_wr_addr = 4'd2;  w4_wr_data = 64'h2; tick();
    w4_wr_addr = 4'd15; w4_wr_data = 64'hF; tick();
    w4_wr_en = 1'b0;
    w4_rd_en = 4'hF;
    for (int k = 0; k < 4; k++) w4_rd_addr[k*4 +: 4] = addrs[k];
    exp_q.push_back(64'h1); exp_q.push_back(64'h2);
    exp_q.push_back(64'h1); exp_q.push_back(64'hF);
    tick();
    w4_rd_en = 4'h0;
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      n_checks++; if (w4_rd_data[k*64 +: 64] !== e) begin n_fail++; $display("FAIL wide_p%0d: got %h want %h", k, w4_rd_data[k*64 +: 64], e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    logic        eb;
    logic [4:0]  a;
    logic [31:0] held_d [2];
    logic        held_b [2];
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mdl_mem[i] = 32'h0;
    mdl_busy = 32'h0;
    held_d[0] = 32'h0; held_d[1] = 32'h0; held_b[0] = 1'b0; held_b[1] = 1'b0;
    for (int c = 0; c < 80; c++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      sb_set  = 1'($urandom_range(0, 1));
      sb_addr = 5'($urandom_range(0, 31));
      rd_en   = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) rd_addr[k*5 +: 5] = 5'($urandom_range(0, 31));
      if (c % 4 == 0) rd_addr[9:5] = wr_addr;
      dbg_addr = 5'($urandom_range(0, 31));
      for (int k = 0; k < 2; k++) begin
        a = rd_addr[k*5 +: 5];
        if (rd_en[k]) begin
          held_d[k] = (wr_en && wr_addr == a && a != 5'd0) ? wr_data : mdl_mem[a];
          held_b[k] = mdl_busy[a] & ~(wr_en && wr_addr == a);
        end
        exp_q.push_back({32'h0, held_d[k]});
        expb_q.push_back(held_b[k]);
      end
      if (wr_en && wr_addr != 5'd0) mdl_mem[wr_addr] = wr_data;
      if (wr_en) mdl_busy[wr_addr] = 1'b0;
      if (sb_set) mdl_busy[sb_addr] = 1'b1;
      mdl_busy[0] = 1'b0;
      tick();
      for (int k = 0; k < 2; k++) begin
        e  = exp_q.pop_front();
        eb = expb_q.pop_front();
        n_checks++; if (rd_data[k*32 +: 32] !== e[31:0]) begin n_fail++; $display("FAIL rand_data c%0d p%0d: got %h want %h", c, k, rd_data[k*32 +: 32], e[31:0]); end
        n_checks++; if (rd_busy[k] !== eb) begin n_fail++; $display("FAIL rand_busy c%0d p%0d: got %b want %b", c, k, rd_busy[k], eb); end
      end
      n_checks++; if (busy_vec !== mdl_busy) begin n_fail++; $display("FAIL rand_vec c%0d: got %h want %h", c, busy_vec, mdl_busy); end
      n_checks++; if (dbg_data !== mdl_mem[dbg_addr]) begin n_fail++; $display("FAIL rand_dbg c%0d: got %h want %h", c, dbg_data, mdl_mem[dbg_addr]); end
    end
    idle_all();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all();
    rd_addr = '0; wr_addr = '0; wr_data = '0; sb_addr = '0; dbg_addr = '0;
    nz_rd_addr = '0; nz_wr_addr = '0; nz_wr_data = '0; nz_sb_addr = '0; nz_dbg_addr = '0;
    w4_rd_addr = '0; w4_wr_addr = '0; w4_wr_data = '0; w4_sb_addr = '0; w4_dbg_addr = '0;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_clear_bypass();
    test_wide();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
